// File: rtl/cpu_pkg.sv
// Shared D-bus datapath constants and the destination-select encoding.
// Imported by the D-bus select and the write-back register file.
package cpu_pkg;

  localparam int DW = 8;
  localparam int AW = 3;

  typedef enum logic [1:0] {
    MD_ALU = 2'b00,
    MD_MEM = 2'b01,
    MD_Y   = 2'b10
  } md_e;

endpackage

// File: rtl/ld_scoreboard.sv
// Single-entry pending-load scoreboard.
// Tracks one outstanding load and flags register hazards against it.
module ld_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW_P = AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_issue,
  input  logic [AW_P-1:0] ld_addr,
  input  logic            ld_valid,
  input  logic            rd_a_en,
  input  logic [AW_P-1:0] src_a_addr,
  input  logic            rd_b_en,
  input  logic [AW_P-1:0] src_b_addr,
  input  logic            wr_en,
  input  logic [AW_P-1:0] dst_addr,
  output logic            pend_v_o,
  output logic [AW_P-1:0] pend_tag_o,
  output logic            ld_ret_o,
  output logic            stall_o,
  output logic            ld_err_o
);

  logic            pend_v_q, pend_v_d;
  logic [AW_P-1:0] pend_tag_q, pend_tag_d;
  logic            ld_err_q, ld_err_d;
  logic            ret, accept;
  logic            hit_a, hit_b, hit_d;

  assign ret    = ld_valid & pend_v_q;
  assign accept = ~pend_v_q | ret;

  // A returning load clears its own hazard in the same cycle.
  assign hit_a = pend_v_q & (pend_tag_q == src_a_addr) & ~ld_valid;
  assign hit_b = pend_v_q & (pend_tag_q == src_b_addr) & ~ld_valid;
  assign hit_d = pend_v_q & (pend_tag_q == dst_addr) & ~ld_valid;

  always_comb begin
    pend_v_d   = pend_v_q;
    pend_tag_d = pend_tag_q;
    ld_err_d   = 1'b0;
    if (ret) pend_v_d = 1'b0;
    if (ld_issue) begin
      if (accept) begin
        pend_v_d   = 1'b1;
        pend_tag_d = ld_addr;
      end else begin
        ld_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v_q   <= 1'b0;
      pend_tag_q <= '0;
      ld_err_q   <= 1'b0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_tag_q <= pend_tag_d;
      ld_err_q   <= ld_err_d;
    end
  end

  assign pend_v_o   = pend_v_q;
  assign pend_tag_o = pend_tag_q;
  assign ld_ret_o   = ret;
  assign ld_err_o   = ld_err_q;
  assign stall_o    = rst_n &
    ((rd_a_en & hit_a) | (rd_b_en & hit_b) | (wr_en & hit_d));

endmodule

// File: rtl/reg_file_wb.sv
// Write-back register file: 8x8 array, two bypassed read ports,
// one write port shared with the returning-load path.
module reg_file_wb #(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d_in,
  input  logic          wr_en,
  input  logic [AW-1:0] dst_addr,
  input  logic          rd_a_en,
  input  logic [AW-1:0] src_a_addr,
  input  logic          rd_b_en,
  input  logic [AW-1:0] src_b_addr,
  input  logic          ld_issue,
  input  logic [AW-1:0] ld_addr,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          stall,
  output logic          ld_busy,
  output logic          ld_err
);

  localparam int NR = 2 ** AW;

  logic [DW-1:0] regs_q [NR];
  logic [DW-1:0] regs_d [NR];
  logic          pend_v, ld_ret, wr_eff;
  logic [AW-1:0] pend_tag;
  logic [DW-1:0] a_mux, b_mux;

  ld_scoreboard #(.AW_P(AW)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_issue   (ld_issue),
    .ld_addr    (ld_addr),
    .ld_valid   (ld_valid),
    .rd_a_en    (rd_a_en),
    .src_a_addr (src_a_addr),
    .rd_b_en    (rd_b_en),
    .src_b_addr (src_b_addr),
    .wr_en      (wr_en),
    .dst_addr   (dst_addr),
    .pend_v_o   (pend_v),
    .pend_tag_o (pend_tag),
    .ld_ret_o   (ld_ret),
    .stall_o    (stall),
    .ld_err_o   (ld_err)
  );

  assign wr_eff = wr_en & ~stall;

  // Load return first, then the younger D-bus write overrides it.
  always_comb begin
    regs_d = regs_q;
    if (ld_ret) regs_d[pend_tag] = ld_data;
    if (wr_eff) regs_d[dst_addr] = d_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    a_mux = regs_q[src_a_addr];
    if (wr_eff && dst_addr == src_a_addr)
      a_mux = d_in;
    else if (ld_ret && pend_tag == src_a_addr)
      a_mux = ld_data;
  end

  always_comb begin
    b_mux = regs_q[src_b_addr];
    if (wr_eff && dst_addr == src_b_addr)
      b_mux = d_in;
    else if (ld_ret && pend_tag == src_b_addr)
      b_mux = ld_data;
  end

  assign a_out   = rst_n ? a_mux : '0;
  assign b_out   = rst_n ? b_mux : '0;
  assign ld_busy = pend_v;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: bypass, load hazards,
// issue rejection, same-register ordering and mid-load reset.
module tb_reg_file_wb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d_in, ld_data, a_out, b_out;
  logic       wr_en, rd_a_en, rd_b_en;
  logic       ld_issue, ld_valid;
  logic [2:0] dst_addr, src_a_addr, src_b_addr, ld_addr;
  logic       stall, ld_busy, ld_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .wr_en      (wr_en),
    .dst_addr   (dst_addr),
    .rd_a_en    (rd_a_en),
    .src_a_addr (src_a_addr),
    .rd_b_en    (rd_b_en),
    .src_b_addr (src_b_addr),
    .ld_issue   (ld_issue),
    .ld_addr    (ld_addr),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .a_out      (a_out),
    .b_out      (b_out),
    .stall      (stall),
    .ld_busy    (ld_busy),
    .ld_err     (ld_err)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input string tag,
                        input logic [2:0] a,
                        input logic [7:0] exp);
    src_a_addr = a;
    #1;
    check(tag, a_out, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    d_in = '0; ld_data = '0;
    wr_en = 0; rd_a_en = 0; rd_b_en = 0;
    ld_issue = 0; ld_valid = 0;
    dst_addr = '0; src_a_addr = '0;
    src_b_addr = '0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    src_a_addr = 3; src_b_addr = 7;
    #1;
    check("rst_a", a_out, 8'h00);
    check("rst_b", b_out, 8'h00);
    check("rst_stall", {7'd0, stall}, 8'd0);
    check("rst_busy", {7'd0, ld_busy}, 8'd0);

    wr_en = 1; dst_addr = 2; d_in = 8'hA5; src_a_addr = 2;
    #1 check("wr_bypass", a_out, 8'hA5);
    tick();
    wr_en = 0;
    #1 check("wr_stored", a_out, 8'hA5);

    ld_issue = 1; ld_addr = 5;
    tick();
    ld_issue = 0;
    check("ld_busy_set", {7'd0, ld_busy}, 8'd1);
    rd_a_en = 1; src_a_addr = 5;
    wr_en = 1; dst_addr = 1; d_in = 8'h77;
    #1 check("hazard_stall", {7'd0, stall}, 8'd1);
    tick();
    wr_en = 0;
    ld_valid = 1; ld_data = 8'h3C;
    #1;
    check("ret_nostall", {7'd0, stall}, 8'd0);
    check("ret_bypass", a_out, 8'h3C);
    tick();
    ld_valid = 0; rd_a_en = 0;
    check("ret_busy_clr", {7'd0, ld_busy}, 8'd0);
    rd_reg("r5_loaded", 5, 8'h3C);
    rd_reg("r1_blocked", 1, 8'h00);

    ld_issue = 1; ld_addr = 6;
    tick();
    ld_addr = 4;
    check("err_idle", {7'd0, ld_err}, 8'd0);
    tick();
    ld_issue = 0;
    check("err_pulse", {7'd0, ld_err}, 8'd1);
    tick();
    check("err_clear", {7'd0, ld_err}, 8'd0);
    rd_a_en = 1; src_a_addr = 6;
    #1 check("tag6_kept", {7'd0, stall}, 8'd1);
    src_a_addr = 4;
    #1 check("tag4_free", {7'd0, stall}, 8'd0);
    rd_a_en = 0;
    ld_issue = 1; ld_addr = 4;
    ld_valid = 1; ld_data = 8'h99;
    tick();
    ld_issue = 0; ld_valid = 0;
    check("retry_noerr", {7'd0, ld_err}, 8'd0);
    check("retry_busy", {7'd0, ld_busy}, 8'd1);
    rd_reg("r6_loaded", 6, 8'h99);
    rd_a_en = 1; src_a_addr = 4;
    #1 check("tag4_pend", {7'd0, stall}, 8'd1);
    rd_a_en = 0;
    ld_valid = 1; ld_data = 8'h44;
    tick();
    ld_valid = 0;
    rd_reg("r4_loaded", 4, 8'h44);

    ld_issue = 1; ld_addr = 3;
    tick();
    ld_issue = 0;
    ld_valid = 1; ld_data = 8'h11;
    wr_en = 1; dst_addr = 3; d_in = 8'h22;
    rd_a_en = 1; src_a_addr = 3;
    #1;
    check("coll_nostall", {7'd0, stall}, 8'd0);
    check("coll_bypass", a_out, 8'h22);
    tick();
    ld_valid = 0; wr_en = 0; rd_a_en = 0;
    rd_reg("coll_r3", 3, 8'h22);
    check("coll_busy", {7'd0, ld_busy}, 8'd0);

    ld_issue = 1; ld_addr = 3;
    wr_en = 1; dst_addr = 3; d_in = 8'h55;
    tick();
    ld_issue = 0; wr_en = 0;
    rd_reg("issue_wr_r3", 3, 8'h55);
    check("issue_wr_busy", {7'd0, ld_busy}, 8'd1);
    ld_valid = 1; ld_data = 8'h66;
    tick();
    ld_valid = 0;
    rd_reg("late_ld_r3", 3, 8'h66);

    ld_issue = 1; ld_addr = 1;
    tick();
    ld_issue = 0;
    check("mid_busy", {7'd0, ld_busy}, 8'd1);
    wr_en = 1; dst_addr = 0; d_in = 8'hAB; src_a_addr = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {7'd0, ld_busy}, 8'd0);
    check("arst_a", a_out, 8'h00);
    check("arst_stall", {7'd0, stall}, 8'd0);
    wr_en = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ld_valid = 1; ld_data = 8'hFF;
    tick();
    ld_valid = 0;
    rd_reg("stale_ld_r1", 1, 8'h00);
    rd_reg("arst_r3", 3, 8'h00);
    check("post_busy", {7'd0, ld_busy}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
